// File: rtl/dff_bank_arb_pkg.sv
// Shared types, defaults and helpers for the register-bank write arbiter.
package dff_bank_arb_pkg;

    localparam int unsigned DEF_NUM_REQ  = 4;
    localparam int unsigned DEF_NUM_REGS = 8;
    localparam int unsigned DEF_DATA_W   = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Ceiling log2 with a floor of 1 so that single-entry fields still get a bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 1) ? n - 1 : 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin picker: first set bit of elig at or after ptr,
// ascending with wrap-around. Reusable by any arbiter of NUM_REQ requesters.
module rr_prio_pick
    import dff_bank_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned PTR_W  = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    int unsigned       idx_int;
    logic [PTR_W-1:0]  idx;

    // Walk NUM_REQ slots starting at ptr; the first eligible one wins.
    always_comb begin
        pick    = '0;
        valid   = 1'b0;
        idx_int = 0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx_int = (32'(ptr) + i) % NUM_REQ;
            idx     = PTR_W'(idx_int);
            if (!valid && elig[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter driving a bank of enable-gated registers.
// Optional macro DFF_BANK_ARB_ERR_EN adds o_err, pulsing alongside a grant
// whose target address lies outside the bank.
module dff_bank_arbiter
    import dff_bank_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    localparam int unsigned ADDR_W  = clog2(NUM_REGS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_data,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [NUM_REGS-1:0]       o_en,
    output logic [DATA_W-1:0]         o_d,
    output logic                      o_busy
`ifdef DFF_BANK_ARB_ERR_EN
    ,
    output logic                      o_err
`endif
);

    localparam int unsigned PTR_W = clog2(NUM_REQ);

    arb_state_t           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   pick;
    logic                 pick_valid;
    logic [PTR_W-1:0]     sel_idx;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;
    logic                 in_range;
    logic [NUM_REQ-1:0]   gnt_d;
    logic [NUM_REGS-1:0]  en_d;
    logic [DATA_W-1:0]    d_d;

    // Last cycle's winner sits out one edge so nobody is granted twice in a row.
    assign elig = i_req & ~o_gnt;

    rr_prio_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .elig  (elig),
        .ptr   (ptr_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    // Mux the winning requester's index, address and data off the packed buses.
    always_comb begin
        sel_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                sel_idx  = PTR_W'(i);
                sel_addr = i_addr[i*ADDR_W +: ADDR_W];
                sel_data = i_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_range = (32'(sel_addr) < NUM_REGS);

    // Next state, pointer advance and next registered outputs.
    always_comb begin
        state_d = ST_IDLE;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        en_d    = '0;
        d_d     = '0;
        if (pick_valid) begin
            state_d = ST_GRANT;
            gnt_d   = pick;
            d_d     = sel_data;
            if (in_range) begin
                en_d[sel_addr] = 1'b1;
            end
            ptr_d = (32'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + 1'b1;
        end
    end

    // State, pointer and bank-facing output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            o_gnt   <= '0;
            o_en    <= '0;
            o_d     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            o_gnt   <= gnt_d;
            o_en    <= en_d;
            o_d     <= d_d;
        end
    end

    assign o_busy = (state_q == ST_GRANT);

`ifdef DFF_BANK_ARB_ERR_EN
    // Flag a grant whose address has no register behind it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else begin
            o_err <= pick_valid && !in_range;
        end
    end
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench: directed vector table, async-reset sequence and a
// randomized run against a behavioural arbitration model. Two instances are
// driven in parallel: an 8-register bank and a 6-register bank.
module tb_dff_bank_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] addr;
    logic [31:0] data;

    logic [3:0]  gnt8, gnt6;
    logic [7:0]  en8;
    logic [5:0]  en6;
    logic [7:0]  d8, d6;
    logic        busy8, busy6;
`ifdef DFF_BANK_ARB_ERR_EN
    logic        err8, err6;
`endif

    int vectors;
    int errors;
    int m_ptr;
    int m_last;

    dff_bank_arbiter #(.NUM_REQ(4), .NUM_REGS(8), .DATA_W(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr(addr), .i_data(data),
        .o_gnt(gnt8), .o_en(en8), .o_d(d8), .o_busy(busy8)
`ifdef DFF_BANK_ARB_ERR_EN
        , .o_err(err8)
`endif
    );

    dff_bank_arbiter #(.NUM_REQ(4), .NUM_REGS(6), .DATA_W(8)) dut6 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr(addr), .i_data(data),
        .o_gnt(gnt6), .o_en(en6), .o_d(d6), .o_busy(busy6)
`ifdef DFF_BANK_ARB_ERR_EN
        , .o_err(err6)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [7:0]  en8;
        logic [5:0]  en6;
        logic [7:0]  d;
        logic        oor;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eg, input logic [7:0] ee8,
                           input logic [5:0] ee6, input logic [7:0] ed, input logic eo6);
        chk({tag, ".gnt8"},  32'(gnt8),  32'(eg));
        chk({tag, ".gnt6"},  32'(gnt6),  32'(eg));
        chk({tag, ".en8"},   32'(en8),   32'(ee8));
        chk({tag, ".en6"},   32'(en6),   32'(ee6));
        chk({tag, ".d8"},    32'(d8),    32'(ed));
        chk({tag, ".d6"},    32'(d6),    32'(ed));
        chk({tag, ".busy8"}, 32'(busy8), 32'(eg != 4'b0));
        chk({tag, ".busy6"}, 32'(busy6), 32'(eg != 4'b0));
`ifdef DFF_BANK_ARB_ERR_EN
        chk({tag, ".err8"},  32'(err8),  32'(0));
        chk({tag, ".err6"},  32'(err6),  32'(eo6));
`else
        if (eo6 === 1'bx) $display("unexpected X in expectation");
`endif
    endtask

    // Reference: rotate from the pointer, skip last cycle's winner, take the first asker.
    task automatic model_step(output logic [3:0] eg, output logic [7:0] ee8,
                              output logic [5:0] ee6, output logic [7:0] ed,
                              output logic eo6);
        int k;
        int a;
        k   = -1;
        eg  = '0; ee8 = '0; ee6 = '0; ed = '0; eo6 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int idx;
            idx = (m_ptr + i) % 4;
            if (k < 0 && req[idx] && idx != m_last) k = idx;
        end
        if (k >= 0) begin
            a   = int'((addr >> (3 * k)) & 12'h7);
            eg  = 4'(1 << k);
            ee8 = 8'(1 << a);
            ee6 = (a < 6) ? 6'(1 << a) : 6'b0;
            eo6 = (a >= 6);
            ed  = data[8*k +: 8];
            m_ptr  = (k + 1) % 4;
            m_last = k;
        end else begin
            m_last = -1;
        end
    endtask

    initial begin
        logic [3:0] eg;
        logic [7:0] ee8;
        logic [5:0] ee6;
        logic [7:0] ed;
        logic       eo6;

        vectors = 0;
        errors  = 0;
        rst  = 1'b1;
        req  = '0;
        addr = '0;
        data = '0;

        tbl[0]  = '{4'b0000, 12'h000, 32'h00000000, 4'b0000, 8'h00, 6'h00, 8'h00, 1'b0};
        tbl[1]  = '{4'b0100, 12'h140, 32'h00A50000, 4'b0100, 8'h20, 6'h20, 8'hA5, 1'b0};
        tbl[2]  = '{4'b0000, 12'h140, 32'h00A50000, 4'b0000, 8'h00, 6'h00, 8'h00, 1'b0};
        tbl[3]  = '{4'b1111, 12'h8D1, 32'h13121110, 4'b1000, 8'h10, 6'h10, 8'h13, 1'b0};
        tbl[4]  = '{4'b1111, 12'h8D1, 32'h13121110, 4'b0001, 8'h02, 6'h02, 8'h10, 1'b0};
        tbl[5]  = '{4'b1111, 12'h8D1, 32'h13121110, 4'b0010, 8'h04, 6'h04, 8'h11, 1'b0};
        tbl[6]  = '{4'b1111, 12'h8D1, 32'h13121110, 4'b0100, 8'h08, 6'h08, 8'h12, 1'b0};
        tbl[7]  = '{4'b1111, 12'h8D1, 32'h13121110, 4'b1000, 8'h10, 6'h10, 8'h13, 1'b0};
        tbl[8]  = '{4'b1111, 12'h8D1, 32'h13121110, 4'b0001, 8'h02, 6'h02, 8'h10, 1'b0};
        tbl[9]  = '{4'b0010, 12'h8D1, 32'h13121110, 4'b0010, 8'h04, 6'h04, 8'h11, 1'b0};
        tbl[10] = '{4'b0010, 12'h8D1, 32'h13121110, 4'b0000, 8'h00, 6'h00, 8'h00, 1'b0};
        tbl[11] = '{4'b0010, 12'h8D1, 32'h13121110, 4'b0010, 8'h04, 6'h04, 8'h11, 1'b0};
        tbl[12] = '{4'b0010, 12'h8D1, 32'h13121110, 4'b0000, 8'h00, 6'h00, 8'h00, 1'b0};
        tbl[13] = '{4'b0001, 12'h8D7, 32'h13121110, 4'b0001, 8'h80, 6'h00, 8'h10, 1'b1};
        tbl[14] = '{4'b0000, 12'h8D7, 32'h13121110, 4'b0000, 8'h00, 6'h00, 8'h00, 1'b0};

        // Reset state
        repeat (2) tick();
        chk_all("reset", 4'b0, 8'h0, 6'h0, 8'h0, 1'b0);
        rst = 1'b0;

        // Idle: no requests for 10 cycles
        for (int c = 0; c < 10; c++) begin
            tick();
            chk_all("idle", 4'b0, 8'h0, 6'h0, 8'h0, 1'b0);
        end

        // Directed vector table
        for (int r = 0; r < 15; r++) begin
            req  = tbl[r].req;
            addr = tbl[r].addr;
            data = tbl[r].data;
            tick();
            chk_all($sformatf("tbl%0d", r), tbl[r].gnt, tbl[r].en8, tbl[r].en6, tbl[r].d, tbl[r].oor);
        end

        // Asynchronous reset while requester 1 holds the grant
        req  = 4'b0010;
        addr = 12'h8D1;
        data = 32'h13121110;
        tick();
        chk("arst.pre_gnt", 32'(gnt8), 32'(4'b0010));
        chk("arst.pre_en",  32'(en8),  32'(8'h04));
        #2 rst = 1'b1;
        #1;
        chk_all("arst.mid", 4'b0, 8'h0, 6'h0, 8'h0, 1'b0);
        #1 rst = 1'b0;
        req = 4'b0110;
        tick();
        chk_all("arst.after", 4'b0010, 8'h04, 6'h04, 8'h11, 1'b0);

        // Randomized run against the reference model
        req = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        m_ptr  = 0;
        m_last = -1;
        for (int c = 0; c < 400; c++) begin
            req  = 4'($urandom_range(0, 15));
            addr = 12'($urandom);
            data = $urandom;
            model_step(eg, ee8, ee6, ed, eo6);
            tick();
            chk_all("rand", eg, ee8, ee6, ed, eo6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
Round-robin write arbiter in front of a bank of NUM_REGS enable-gated D flip-flop registers (async reset, posedge clock, per-register enable).
- Up to NUM_REQ requesters each post a register address and data word.
- Grants at most one requester per cycle.
- Drives the bank's one-hot enable vector and shared data bus, so the bank never sees two simultaneous writers.
- Sits between software/control-path masters and the shared register bank.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
NUM_REGS, 8, number of registers in the controlled bank (2..256)
DATA_W, 8, width of each register / write data
ADDR_W, clog2(NUM_REGS) (minimum 1), register address width, derived; not for override

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_req  in  NUM_REQ  per-requester write request, level
i_addr  in  NUM_REQ*ADDR_W  packed target addresses; requester k at [k*ADDR_W +: ADDR_W]
i_data  in  NUM_REQ*DATA_W  packed write data; requester k at [k*DATA_W +: DATA_W]
o_gnt  out  NUM_REQ  one-hot grant pulse, registered
o_en  out  NUM_REGS  one-hot enable vector to the register bank, registered
o_d  out  DATA_W  write data to the register bank, registered
o_busy  out  1  high in any cycle where o_gnt is non-zero

Behaviour:
- Reset: i_rst=1 asynchronously clears the following, with no write reaching the bank:
  - o_gnt=0, o_en=0, o_d=0, o_busy=0
  - round-robin pointer ptr=0
  - FSM=IDLE
- FSM, two states:
  - IDLE: outputs zero.
  - GRANT: exactly one o_gnt bit high, lasting one cycle.
  - Transitions are evaluated every rising edge:
    - Any eligible request -> GRANT, including GRANT->GRANT back-to-back for different requesters.
    - No eligible request -> IDLE.
- Eligible set = i_req & ~o_gnt. The requester granted this cycle is masked at the next edge, so it cannot be regranted on consecutive cycles.
- Arbitration: search for the first eligible index starting at ptr, ascending, wrapping NUM_REQ-1 -> 0. After granting k, ptr <= (k+1) mod NUM_REQ. ptr is unchanged when no grant is issued.
- Latency:
  - Request sampled at edge t.
  - o_gnt[k], o_en[i_addr[k]] and o_d=i_data[k] become valid after edge t.
  - Bank captures the data at edge t+1.
  - Total: one cycle from request to enable, two cycles from request to the register holding the value.
- Requester handshake:
  - Hold i_req, i_addr and i_data stable until o_gnt[k] is sampled high.
  - Drop i_req on that same edge, or keep it high to issue a new write; that write becomes eligible one cycle later.
- Out-of-range address (i_addr >= NUM_REGS, possible only when NUM_REGS is not a power of 2):
  - The grant is still issued and the pointer still advances.
  - o_en stays all-zero (write dropped).
  - o_d is still driven.
- o_en is always one-hot or zero, never multi-hot. o_gnt is always one-hot or zero.
- Reset asserted mid-grant clears o_en immediately; the pending write is lost. Requesters retry after reset.

Optional Feature:
DFF_BANK_ARB_ERR_EN
- Defined: adds output o_err (1 bit, registered, reset 0). o_err pulses high in the same cycle as an o_gnt whose address is out of range.
- Undefined: the port is absent and out-of-range writes are silently dropped.

Decomposition:
- Package dff_bank_arb_pkg holds:
  - a clog2 function
  - state encoding constants (ST_IDLE=0, ST_GRANT=1)
  - defaults for NUM_REQ, NUM_REGS, DATA_W
- Sub-module rr_prio_pick (combinational): inputs eligible vector and ptr; outputs one-hot pick and valid. Parameterised by NUM_REQ and reusable by other arbiters.
- Top level contains the FSM, pointer register, address decode and output registers.

Test Plan:
- Reset, then all i_req=0 for 10 cycles -> o_gnt, o_en and o_busy stay 0; o_d=0.
- Single requester 2, addr=5, data=0xA5 -> next cycle o_gnt=0b0100, o_en=0x20, o_d=0xA5; one pulse only. Requester drops req and o_gnt returns to 0.
- All four requesters held high continuously -> grants in order 0,1,2,3,0,... with one grant per cycle and o_busy constantly 1.
- Only requester 1 held high continuously -> o_gnt[1] pulses every second cycle (masking rule) and ptr stays valid.
- NUM_REGS=6, requester 0 addr=7 -> o_gnt[0]=1, o_en=0. With DFF_BANK_ARB_ERR_EN defined, o_err=1 for that cycle.
- i_rst asserted asynchronously while o_gnt=0b0010 -> o_en and o_gnt drop immediately with no clock edge. After release, the first grant goes to the lowest eligible index (ptr=0).
